// File: rtl/alu_sequencer.sv
// Instruction sequencer for a combinational 16-bit ALU: four-step IDLE/DECODE/EXEC/WB
// flow over an internal 8-entry register file with single-cycle write-back pulses.
module alu_sequencer #(
  parameter int unsigned WIDTH_DATA = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [15:0]           instr_data,
  output logic                  instr_ready,
  output logic [WIDTH_DATA-1:0] alu_operand_a,
  output logic [WIDTH_DATA-1:0] alu_operand_b,
  output logic [4:0]            alu_op_code,
  input  logic [WIDTH_DATA-1:0] alu_result,
  output logic                  wb_valid,
  output logic [2:0]            wb_addr,
  output logic [WIDTH_DATA-1:0] wb_data,
  output logic                  illegal_op,
  input  logic [2:0]            dbg_addr,
  output logic [WIDTH_DATA-1:0] dbg_data
);

  localparam int unsigned N_REG  = 8;
  localparam int unsigned W_INSN = 16;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t                state_q, state_d;
  logic [W_INSN-1:0]     ir_q, ir_d;
  logic [WIDTH_DATA-1:0] rf [N_REG];

  logic                  ready_d, wbv_d, illegal_d;
  logic [WIDTH_DATA-1:0] opa_d, opb_d, wbd_d;
  logic [4:0]            opc_d;
  logic [2:0]            wba_d;

  logic [4:0] ir_opcode;
  logic [2:0] ir_rd, ir_rs1, ir_rs2;

  assign ir_opcode = ir_q[15:11];
  assign ir_rd     = ir_q[10:8];
  assign ir_rs1    = ir_q[7:5];
  assign ir_rs2    = ir_q[4:2];
  assign dbg_data  = rf[dbg_addr];

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= 5'd4) && (op <= 5'd13);
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return (op == 5'd3) || (op >= 5'd14);
  endfunction

  // Next-state and next-output logic; ALU-facing outputs are zero outside EXEC.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    opa_d     = '0;
    opb_d     = '0;
    opc_d     = '0;
    wbv_d     = 1'b0;
    wba_d     = '0;
    wbd_d     = '0;
    illegal_d = illegal_op;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          ir_d      = instr_data;
          illegal_d = illegal_op | is_illegal(instr_data[15:11]);
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = (ir_opcode == 5'd1) ? WIDTH_DATA'(ir_q[7:0]) : rf[ir_rs1];
        opb_d   = rf[ir_rs2];
        opc_d   = ir_opcode;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_opcode == 5'd1 || ir_opcode == 5'd2 || is_alu_op(ir_opcode)) begin
          wbv_d = 1'b1;
          wba_d = ir_rd;
          wbd_d = is_alu_op(ir_opcode) ? alu_result : alu_operand_a;
        end
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ir_q          <= '0;
      instr_ready   <= 1'b1;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_op_code   <= '0;
      wb_valid      <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      illegal_op    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      instr_ready   <= ready_d;
      alu_operand_a <= opa_d;
      alu_operand_b <= opb_d;
      alu_op_code   <= opc_d;
      wb_valid      <= wbv_d;
      wb_addr       <= wba_d;
      wb_data       <= wbd_d;
      illegal_op    <= illegal_d;
    end
  end

  // Register file commits on the edge that ends the WB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) rf[i] <= '0;
    end else if (wb_valid) begin
      rf[wb_addr] <= wb_data;
    end
  end

endmodule
